// File: rtl/rom_stream_reader_pkg.sv
// Shared types and constants for the ROM stream reader.
//   state_t     : run-control FSM states
//   ADDR_W_DEF  : default word-address width of the memory slave
//   DATA_W_DEF  : default data width
//   BYTEEN_ALL  : all-ones byte-enable vector for a given byte count
package rom_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int BYTEEN_MAX = 64;

  // Returns a vector with the low nbytes bits set; callers size-cast it.
  function automatic logic [BYTEEN_MAX-1:0] BYTEEN_ALL(input int nbytes);
    logic [BYTEEN_MAX-1:0] be;
    be = '0;
    for (int i = 0; i < BYTEEN_MAX; i++) begin
      if (i < nbytes) be[i] = 1'b1;
      else            be[i] = 1'b0;
    end
    return be;
  endfunction

endpackage

// File: rtl/rom_stream_fifo.sv
// Synchronous output FIFO for the ROM stream reader. Each entry carries the
// data word plus sop/eop tag bits. Push and pop in the same cycle are legal,
// also when full. Storage is cleared on reset so the head reads zero.
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset
//   push, push_data   : write strobe and entry
//   pop               : remove head (caller guarantees not empty)
//   head              : current head entry
//   count, empty      : occupancy
module rom_stream_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             full_s;

  // Storage, pointers and occupancy counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head   = mem_r[rd_ptr_r];
  assign count  = count_r;
  assign empty  = (count_r == '0);
  assign full_s = (count_r == CNT_W'(DEPTH));

  rom_stream_fifo_chk u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .full    (full_s),
    .empty   (empty)
  );

endmodule

// Protocol checks for the output FIFO: no overflow, no underflow.
module rom_stream_fifo_chk (
  input logic clk,
  input logic reset_n,
  input logic push,
  input logic pop,
  input logic full,
  input logic empty
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && full && !pop));

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(pop && empty));

endmodule

// File: rtl/rom_stream_reader.sv
// Avalon-MM read master that fetches a run of consecutive words from a
// pipelined memory slave and presents them as an Avalon-ST source.
// Optional feature macro: ROM_STREAM_READER_CHECKSUM_EN adds a `checksum`
// output holding the mod-2^DATA_W sum of the words popped in the current run.
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   start, start_addr, length    : run request (sampled only in IDLE)
//   busy, done                   : run status / one-cycle completion pulse
//   avm_*                        : Avalon-MM read master
//   src_*                        : Avalon-ST source with sop/eop
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEN_W      = 11,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [LEN_W-1:0]    length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic [DATA_W-1:0]   src_data,
  output logic                src_valid,
  input  logic                src_ready,
  output logic                src_sop,
  output logic                src_eop
`ifdef ROM_STREAM_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BE_W  = DATA_W / 8;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** (LEN_W - 1));

  state_t             state_r, state_nxt_s;
  logic [LEN_W-1:0]   len_r, len_clip_s, run_len_s;
  logic [LEN_W-1:0]   issued_r, issued_nxt_s, rx_idx_r;
  logic [CNT_W-1:0]   outstanding_r, outstanding_nxt_s;
  logic [CNT_W-1:0]   fifo_count_s, fifo_count_nxt_s;
  logic [CNT_W:0]     credit_sum_s;
  logic               start_acc_s, accept_s, push_s, pop_s, read_nxt_s;
  logic               fifo_empty_s;
  logic [DATA_W+1:0]  push_word_s, head_s;

  // Handshakes, counter look-ahead and the credit sum used for issuing.
  always_comb begin
    start_acc_s = (state_r == IDLE) && start;
    if (length > MAX_LEN) len_clip_s = MAX_LEN;
    else                  len_clip_s = length;
    if (start_acc_s) run_len_s = len_clip_s;
    else             run_len_s = len_r;
    accept_s = avm_read && !avm_waitrequest;
    // Beats with nothing outstanding belong to a run abandoned by reset.
    push_s = avm_readdatavalid && (outstanding_r != '0);
    pop_s  = src_valid && src_ready;
    if (start_acc_s) issued_nxt_s = '0;
    else             issued_nxt_s = issued_r + LEN_W'(accept_s);
    outstanding_nxt_s = outstanding_r + CNT_W'(accept_s) - CNT_W'(push_s);
    fifo_count_nxt_s  = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    credit_sum_s      = {1'b0, outstanding_nxt_s} + {1'b0, fifo_count_nxt_s};
    push_word_s = {(rx_idx_r == '0), (rx_idx_r == len_r - LEN_W'(1)), avm_readdata};
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (len_clip_s == '0) state_nxt_s = FINISH;
          else                  state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (accept_s && (issued_nxt_s == len_r)) state_nxt_s = DRAIN;
        else                                      state_nxt_s = ISSUE;
      end
      DRAIN: begin
        if ((outstanding_r == '0) && fifo_empty_s) state_nxt_s = FINISH;
        else                                        state_nxt_s = DRAIN;
      end
      FINISH:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Read request for the next cycle: a stalled request is held, otherwise a
  // new one is raised only if the slot is guaranteed a FIFO entry.
  always_comb begin
    read_nxt_s = 1'b0;
    if (state_nxt_s == ISSUE) begin
      if (avm_read && avm_waitrequest) begin
        read_nxt_s = 1'b1;
      end else if ((issued_nxt_s < run_len_s) &&
                   (credit_sum_s < (CNT_W + 1)'(FIFO_DEPTH))) begin
        read_nxt_s = 1'b1;
      end else begin
        read_nxt_s = 1'b0;
      end
    end else begin
      read_nxt_s = 1'b0;
    end
  end

  // Control state, counters and registered Avalon-MM / status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      len_r          <= '0;
      issued_r       <= '0;
      outstanding_r  <= '0;
      rx_idx_r       <= '0;
      avm_read       <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= BE_W'(BYTEEN_ALL(BE_W));
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      issued_r       <= issued_nxt_s;
      outstanding_r  <= outstanding_nxt_s;
      avm_read       <= read_nxt_s;
      avm_byteenable <= BE_W'(BYTEEN_ALL(BE_W));
      busy           <= (state_nxt_s == ISSUE) || (state_nxt_s == DRAIN);
      done           <= (state_r == FINISH);
      if (start_acc_s) begin
        len_r       <= len_clip_s;
        avm_address <= start_addr;
      end else if (accept_s) begin
        avm_address <= avm_address + ADDR_W'(1);
      end
      if (start_acc_s) rx_idx_r <= '0;
      else if (push_s) rx_idx_r <= rx_idx_r + LEN_W'(1);
    end
  end

  rom_stream_fifo #(
    .W     (DATA_W + 2),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_data (push_word_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s)
  );

  assign src_valid = !fifo_empty_s;
  assign src_data  = head_s[DATA_W-1:0];
  assign src_eop   = head_s[DATA_W];
  assign src_sop   = head_s[DATA_W+1];

`ifdef ROM_STREAM_READER_CHECKSUM_EN
  // Running sum of words delivered on the stream during the current run.
  always_ff @(posedge clk) begin
    if (!reset_n)         checksum <= '0;
    else if (start_acc_s) checksum <= '0;
    else if (pop_s)       checksum <= checksum + src_data;
  end
`else
  // Default build: no checksum port or accumulator.
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
module tb_rom_stream_reader;

  logic        clk = 1'b0;
  logic        reset_n, start, busy, done;
  logic [9:0]  start_addr, avm_address;
  logic [10:0] length;
  logic        avm_read, avm_waitrequest, avm_readdatavalid;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata, src_data;
  logic        src_valid, src_ready, src_sop, src_eop;
`ifdef ROM_STREAM_READER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  always #5 clk = ~clk;

  rom_stream_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .length(length), .busy(busy), .done(done), .avm_address(avm_address),
    .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .src_data(src_data),
    .src_valid(src_valid), .src_ready(src_ready), .src_sop(src_sop),
    .src_eop(src_eop)
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [33:0] exp_q[$];       // {sop, eop, data}
  logic [9:0]  exp_addr_q[$];
  logic [9:0]  pend_addr_q[$];
  int          pend_due_q[$];

  int lat = 1, cyc = 0, run_acc = 0, beats_out = 0, max_out = 0;
  int stall_arm = 0, stall_left = 0, stall_obs = 0;
  logic [9:0] stall_addr = 10'd0;
  int done_cnt = 0, run_done0 = 0, read_hi = 0, valid_cycles = 0;

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {22'd0, a} * 32'd3;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory slave: in-order responses with a fixed latency per test.
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (avm_read) read_hi++;
      if (avm_read && avm_waitrequest) begin
        stall_obs++;
        check_eq("stall_addr_hold", 32'(avm_address), 32'(stall_addr));
      end
      if (avm_read && !avm_waitrequest) begin
        run_acc++;
        pend_addr_q.push_back(avm_address);
        pend_due_q.push_back(cyc + lat);
        beats_out++;
        if (beats_out > max_out) max_out = beats_out;
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got addr 0x%0h, expected none", avm_address);
        end else begin
          check_eq("avm_address", 32'(avm_address), 32'(exp_addr_q.pop_front()));
        end
      end
      @(posedge clk);
      #1;
      if (stall_arm != 0 && avm_read && run_acc == 1) begin
        stall_left = 5;
        stall_arm  = 0;
      end
      avm_waitrequest = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc + 1) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = mem_word(pend_addr_q.pop_front());
        void'(pend_due_q.pop_front());
        beats_out--;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'hDEADBEEF;
      end
    end
  end

  // Stream monitor: pops the scoreboard on every handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (src_valid) valid_cycles++;
      if (src_valid && src_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h, expected none", src_data);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          check_eq("src_data", src_data, e[31:0]);
          check_eq("src_sop", 32'(src_sop), 32'(e[33]));
          check_eq("src_eop", 32'(src_eop), 32'(e[32]));
        end
      end
    end
  end

  task automatic start_run(input logic [9:0] a, input int len);
    int n;
    logic [9:0] addr;
    n = (len > 1024) ? 1024 : len;
    for (int i = 0; i < n; i++) begin
      addr = a + 10'(i);
      exp_addr_q.push_back(addr);
      exp_q.push_back({(i == 0), (i == n - 1), mem_word(addr)});
    end
    run_acc = 0; read_hi = 0; valid_cycles = 0; max_out = beats_out;
    run_done0 = done_cnt;
    start_addr = a;
    length = 11'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_cnt == run_done0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == run_done0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done in %0d cycles, expected done", name, budget);
    end
  endtask

  task automatic end_run(input string name, input int n);
    repeat (2) tick();
    check_eq({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
    check_eq({name, "_accepts"}, 32'(run_acc), 32'(n));
    check_eq({name, "_done_pulses"}, 32'(done_cnt - run_done0), 32'd1);
    check_eq({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_avm_read"}, 32'(avm_read), 32'd0);
    check_eq({tag, "_avm_address"}, 32'(avm_address), 32'd0);
    check_eq({tag, "_byteenable"}, 32'(avm_byteenable), 32'hF);
    check_eq({tag, "_src_valid"}, 32'(src_valid), 32'd0);
    check_eq({tag, "_src_sop"}, 32'(src_sop), 32'd0);
    check_eq({tag, "_src_eop"}, 32'(src_eop), 32'd0);
    check_eq({tag, "_src_data"}, src_data, 32'd0);
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    check_eq({tag, "_checksum"}, checksum, 32'd0);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_seen;
    reset_n = 1'b0; start = 1'b0; start_addr = 10'd0; length = 11'd0; src_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // Basic run with latency/throughput checks.
    lat = 1;
    start_run(10'h010, 4);
    lat_seen = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (src_valid) begin
        lat_seen = n;
        break;
      end
    end
    check_eq("first_valid_latency", 32'(lat_seen), 32'd3);
    wait_done("basic", 200);
    end_run("basic", 4);
    check_eq("basic_read_cycles", 32'(read_hi), 32'd4);
    check_eq("basic_valid_cycles", 32'(valid_cycles), 32'd4);
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    check_eq("basic_checksum", checksum, 32'h000000D2);
`endif

    // Address wrap.
    start_run(10'h3FE, 4);
    wait_done("wrap", 200);
    end_run("wrap", 4);

    // Backpressure: consumer stalled for 30 cycles.
    src_ready = 1'b0;
    start_run(10'h020, 20);
    repeat (29) tick();
    @(negedge clk);
    check_eq("bp_accepts_at_full", 32'(run_acc), 32'd8);
    check_eq("bp_read_low_no_credit", 32'(avm_read), 32'd0);
    check_eq("bp_src_valid", 32'(src_valid), 32'd1);
    tick();
    src_ready = 1'b1;
    wait_done("bp", 500);
    end_run("bp", 20);
    check_eq("bp_max_outstanding_le8", 32'(max_out <= 8), 32'd1);

    // waitrequest stall on the second request.
    stall_addr = 10'h101;
    stall_obs  = 0;
    stall_arm  = 1;
    start_run(10'h100, 6);
    wait_done("stall", 300);
    end_run("stall", 6);
    check_eq("stall_cycles", 32'(stall_obs), 32'd5);

    // Zero length: done two cycles after start, no reads.
    start_run(10'h050, 0);
    @(negedge clk);
    check_eq("len0_done_c1", 32'(done), 32'd0);
    @(negedge clk);
    check_eq("len0_done_c2", 32'(done), 32'd1);
    @(negedge clk);
    check_eq("len0_done_c3", 32'(done), 32'd0);
    tick();
    check_eq("len0_reads", 32'(read_hi), 32'd0);
    check_eq("len0_done_pulses", 32'(done_cnt - run_done0), 32'd1);

    // Single word: sop and eop together.
    start_run(10'h07F, 1);
    wait_done("len1", 200);
    end_run("len1", 1);

    // Reset with three reads outstanding.
    lat = 3;
    start_run(10'h200, 20);
    begin
      int n;
      n = 0;
      while (beats_out != 3 && n < 50) begin
        tick();
        n++;
      end
      check_eq("rst_outstanding_reached", 32'(beats_out), 32'd3);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    valid_cycles = 0;
    run_done0 = done_cnt;
    repeat (12) tick();
    check_eq("midrst_no_done", 32'(done_cnt - run_done0), 32'd0);
    check_eq("midrst_no_valid", 32'(valid_cycles), 32'd0);
    check_eq("midrst_stale_drained", 32'(pend_due_q.size()), 32'd0);

    lat = 1;
    start_run(10'h010, 4);
    wait_done("after_rst", 200);
    end_run("after_rst", 4);
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    check_eq("after_rst_checksum", checksum, 32'h000000D2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Avalon-MM read master that drives the instruction/data on-chip memory slave: 32-bit words, 10-bit word address, single-port.
- Fetches a programmed run of consecutive words and presents them as an Avalon-ST source with backpressure.
- Sits between the memory slave and the pixel/sprite consumers of the game platform, replacing CPU-driven copy loops.

Parameters:
- ADDR_W, 10, word-address width of the target slave.
- DATA_W, 32, data width.
- LEN_W, 11, width of the length field; allows 0..1024 words.
- FIFO_DEPTH, 8, output buffer depth in words; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  ADDR_W  first word address.
- length  in  LEN_W  number of words to read.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the run completes.
- avm_address  out  ADDR_W  word address.
- avm_read  out  1  read request.
- avm_byteenable  out  DATA_W/8  constant all-ones.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  DATA_W  read data.
- avm_readdatavalid  in  1  read data valid; the slave is pipelined with variable latency of 1 or more cycles.
- src_data  out  DATA_W  stream data (FIFO head).
- src_valid  out  1  stream valid.
- src_ready  in  1  stream ready.
- src_sop  out  1  first word of the run.
- src_eop  out  1  last word of the run.

Behaviour:
- Reset (reset_n low at a clock edge) values:
  - State IDLE; all outputs 0 except avm_byteenable, which is all-ones.
  - FIFO emptied; counters cleared.
  - Reset mid-run abandons the run: no done pulse, and late readdatavalid beats arriving after reset are discarded.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
  - IDLE: on start, latch start_addr and length, then go to ISSUE. If length is 0, go to FINISH instead.
  - ISSUE: avm_read is asserted while issued < length and credit is available.
    - Credit rule: outstanding + fifo_count < FIFO_DEPTH.
    - A request is accepted when avm_read is high and avm_waitrequest is low. On acceptance, avm_address increments and wraps modulo 2^ADDR_W; issued and outstanding increment.
    - While waitrequest is high, avm_read and avm_address hold stable.
    - Go to DRAIN when issued == length and the last request has been accepted.
  - DRAIN: wait until outstanding == 0 and the FIFO is empty, then go to FINISH.
  - FINISH: done = 1 for exactly one cycle, busy = 0, then IDLE.
- Responses:
  - Each readdatavalid beat is written to the FIFO and decrements outstanding.
  - Overflow is impossible by the credit rule. An overflow is an assertion failure in simulation.
  - A request acceptance and a readdatavalid beat in the same cycle leave outstanding unchanged.
- Stream:
  - src_valid = FIFO not empty. A pop occurs when src_valid and src_ready are both high.
  - src_sop is high on the word with run index 0; src_eop on the word with index length-1. Both apply for length 1.
  - Data, sop and eop hold stable while valid is high and ready is low.
  - A push and a pop in the same cycle, including on a full FIFO, are legal.
- Timing:
  - Earliest avm_read is the cycle after start is accepted.
  - With readdata latency 1 and src_ready held high, the first src_valid appears 3 cycles after start and throughput is 1 word per cycle.
- start while busy is ignored. The length field saturates semantics at 1024; values above 1024 are clipped to 1024.

Optional Feature:
- Macro: ROM_STREAM_READER_CHECKSUM_EN.
- When defined:
  - Extra output port checksum [DATA_W-1:0]: the modulo-2^32 sum of all words popped in the current run.
  - Cleared when start is accepted; valid and stable from the done pulse until the next accepted start.
  - Reset value 0.
- When undefined: the port and its logic are absent.

Decomposition:
- Package rom_stream_reader_pkg holds:
  - state enum (IDLE, ISSUE, DRAIN, FINISH);
  - default width constants ADDR_W_DEF = 10, DATA_W_DEF = 32;
  - BYTEEN_ALL function.
- One sub-module: rom_stream_fifo.
  - Synchronous FIFO of depth FIFO_DEPTH, with count output and active-low sync reset.
  - Holds data plus sop/eop tag bits.

Test Plan:
- Basic run: start_addr = 0x010, length = 4, memory word = address*3, src_ready = 1 -> src_data 0x30, 0x33, 0x36, 0x39; sop on first, eop on fourth; a single done pulse; avm_read asserted for exactly 4 accepted cycles.
- Wrap-around: start_addr = 0x3FE, length = 4 -> avm_address sequence 0x3FE, 0x3FF, 0x000, 0x001; data order preserved.
- Backpressure: length = 20, src_ready low for 30 cycles after start -> FIFO fills to 8; avm_read low while credit = 0; no data lost or duplicated once ready rises; outstanding never exceeds 8.
- waitrequest stall: waitrequest high for 5 cycles on the second request -> avm_address held at start_addr+1 throughout the stall; all words still correct.
- Edge lengths:
  - length = 0 -> done pulse 2 cycles after start, no avm_read.
  - length = 1 -> one word with sop = eop = 1.
- Reset mid-run: reset_n low for 1 cycle with 3 reads outstanding -> outputs at reset values; late readdatavalid beats discarded; no done pulse; a new start afterwards completes normally. With ROM_STREAM_READER_CHECKSUM_EN, the basic run gives checksum = 0x000000D2.
